rs_age_station: RTL and testbench

Parametrised successor to the single ALU reservation station, sitting between the ROB dispatch/broadcast path and one functional unit. It holds up to DEPTH pending micro-ops and wakes up their operands and NZCV from ROB broadcasts, including a broadcast that arrives on the same cycle as dispatch. It issues the oldest ready entry, in dispatch order, over a valid/ready handshake. On a mispredict it selectively squashes entries younger than the mispredicted ROB index.

---
 rtl/rs_age_station_if.sv | 67 ++++++
 rtl/rs_age_station.sv | 159 +++++++++++++++
 tb/tb_rs_age_station.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_age_station_if.sv
// Dispatch, broadcast, squash and issue signals between the ROB/FU side (master)
// and the age-ordered reservation station (slave).
interface rs_age_station_if #(
    parameter int IDX_W     = 3,
    parameter int VAL_W     = 64,
    parameter int ROB_IDX_W = 4,
    parameter int OP_W      = 5
);
    logic                 in_rob_done;
    logic                 out_rs_ready;
    logic [OP_W-1:0]      in_rob_fu_op;
    logic                 in_rob_val_a_valid;
    logic [VAL_W-1:0]     in_rob_val_a_value;
    logic [ROB_IDX_W-1:0] in_rob_val_a_rob_index;
    logic                 in_rob_val_b_valid;
    logic [VAL_W-1:0]     in_rob_val_b_value;
    logic [ROB_IDX_W-1:0] in_rob_val_b_rob_index;
    logic                 in_rob_instr_uses_nzcv;
    logic                 in_rob_nzcv_valid;
    logic [3:0]           in_rob_nzcv;
    logic [ROB_IDX_W-1:0] in_rob_nzcv_rob_index;
    logic                 in_rob_set_nzcv;
    logic [ROB_IDX_W-1:0] in_rob_dst_rob_index;
    logic                 in_rob_broadcast_done;
    logic [ROB_IDX_W-1:0] in_rob_broadcast_index;
    logic [VAL_W-1:0]     in_rob_broadcast_value;
    logic                 in_rob_broadcast_set_nzcv;
    logic [3:0]           in_rob_broadcast_nzcv;
    logic                 in_rob_is_mispred;
    logic [ROB_IDX_W-1:0] in_rob_mispred_index;
    logic [ROB_IDX_W-1:0] in_rob_head_index;
    logic                 in_fu_ready;
    logic                 out_fu_start;
    logic [OP_W-1:0]      out_fu_op;
    logic [VAL_W-1:0]     out_fu_val_a;
    logic [VAL_W-1:0]     out_fu_val_b;
    logic [ROB_IDX_W-1:0] out_fu_dst_rob_index;
    logic                 out_fu_set_nzcv;
    logic [3:0]           out_fu_nzcv;
    logic [IDX_W:0]       out_rs_count;

    modport master (
        output in_rob_done, in_rob_fu_op,
               in_rob_val_a_valid, in_rob_val_a_value, in_rob_val_a_rob_index,
               in_rob_val_b_valid, in_rob_val_b_value, in_rob_val_b_rob_index,
               in_rob_instr_uses_nzcv, in_rob_nzcv_valid, in_rob_nzcv, in_rob_nzcv_rob_index,
               in_rob_set_nzcv, in_rob_dst_rob_index,
               in_rob_broadcast_done, in_rob_broadcast_index, in_rob_broadcast_value,
               in_rob_broadcast_set_nzcv, in_rob_broadcast_nzcv,
               in_rob_is_mispred, in_rob_mispred_index, in_rob_head_index, in_fu_ready,
        input  out_rs_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
               out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv, out_rs_count
    );

    modport slave (
        input  in_rob_done, in_rob_fu_op,
               in_rob_val_a_valid, in_rob_val_a_value, in_rob_val_a_rob_index,
               in_rob_val_b_valid, in_rob_val_b_value, in_rob_val_b_rob_index,
               in_rob_instr_uses_nzcv, in_rob_nzcv_valid, in_rob_nzcv, in_rob_nzcv_rob_index,
               in_rob_set_nzcv, in_rob_dst_rob_index,
               in_rob_broadcast_done, in_rob_broadcast_index, in_rob_broadcast_value,
               in_rob_broadcast_set_nzcv, in_rob_broadcast_nzcv,
               in_rob_is_mispred, in_rob_mispred_index, in_rob_head_index, in_fu_ready,
        output out_rs_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
               out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv, out_rs_count
    );
endinterface

// File: rtl/rs_age_station.sv
// Age-matrix reservation station: operand/NZCV wakeup with dispatch bypass,
// oldest-ready issue, and selective squash of entries younger than a mispredict.
module rs_age_station #(
    parameter int DEPTH     = 8,
    parameter int IDX_W     = 3,
    parameter int VAL_W     = 64,
    parameter int ROB_IDX_W = 4,
    parameter int OP_W      = 5
) (
    input  logic            in_clk,
    input  logic            in_rst,
    rs_age_station_if.slave bus
);
    typedef logic [ROB_IDX_W-1:0] tag_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [IDX_W:0]   count_q, count_d;

    logic [OP_W-1:0]  op_q     [DEPTH];
    logic [VAL_W-1:0] a_val_q  [DEPTH];
    logic [VAL_W-1:0] b_val_q  [DEPTH];
    tag_t             a_tag_q  [DEPTH];
    tag_t             b_tag_q  [DEPTH];
    tag_t             nz_tag_q [DEPTH];
    tag_t             dst_q    [DEPTH];
    logic [3:0]       nz_val_q [DEPTH];
    logic [DEPTH-1:0] a_vld_q, b_vld_q, nz_vld_q, use_nz_q, set_nz_q;

    logic [DEPTH-1:0] rdy, grant, squash, wake_a, wake_b, wake_nz;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W:0]   n_sq;
    logic             fu_start, issue_fire, rs_ready, disp_ok;
    logic             a_hit, b_hit, nz_hit;
    tag_t             mis_age, bidx;

    // Distance from the ROB head; larger means younger.
    function automatic tag_t rob_age(input tag_t x, input tag_t head);
        return x - head;
    endfunction

    assign bidx     = bus.in_rob_broadcast_index;
    assign mis_age  = rob_age(bus.in_rob_mispred_index, bus.in_rob_head_index);
    assign fu_start = (|rdy) & ~bus.in_rob_is_mispred;
    assign issue_fire = fu_start & bus.in_fu_ready;
    assign rs_ready = (count_q != (IDX_W+1)'(DEPTH));
    assign disp_ok  = bus.in_rob_done & rs_ready &
                      ~(bus.in_rob_is_mispred &
                        (rob_age(bus.in_rob_dst_rob_index, bus.in_rob_head_index) > mis_age));

    // Same-cycle broadcast is folded into the dispatching entry.
    assign a_hit  = ~bus.in_rob_val_a_valid & bus.in_rob_broadcast_done & (bus.in_rob_val_a_rob_index == bidx);
    assign b_hit  = ~bus.in_rob_val_b_valid & bus.in_rob_broadcast_done & (bus.in_rob_val_b_rob_index == bidx);
    assign nz_hit = ~bus.in_rob_nzcv_valid & bus.in_rob_broadcast_done & bus.in_rob_broadcast_set_nzcv &
                    (bus.in_rob_nzcv_rob_index == bidx);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = valid_q[i] & a_vld_q[i] & b_vld_q[i] & (~use_nz_q[i] | nz_vld_q[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            grant[i]   = rdy[i] & ~|(age_q[i] & rdy);
            squash[i]  = bus.in_rob_is_mispred & valid_q[i] &
                         (rob_age(dst_q[i], bus.in_rob_head_index) > mis_age);
            wake_a[i]  = bus.in_rob_broadcast_done & ~a_vld_q[i] & (a_tag_q[i] == bidx);
            wake_b[i]  = bus.in_rob_broadcast_done & ~b_vld_q[i] & (b_tag_q[i] == bidx);
            wake_nz[i] = bus.in_rob_broadcast_done & bus.in_rob_broadcast_set_nzcv &
                         ~nz_vld_q[i] & (nz_tag_q[i] == bidx);
        end
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        bus.out_fu_op            = '0;
        bus.out_fu_val_a         = '0;
        bus.out_fu_val_b         = '0;
        bus.out_fu_dst_rob_index = '0;
        bus.out_fu_set_nzcv      = 1'b0;
        bus.out_fu_nzcv          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fu_start && grant[i]) begin
                bus.out_fu_op            = op_q[i];
                bus.out_fu_val_a         = a_val_q[i];
                bus.out_fu_val_b         = b_val_q[i];
                bus.out_fu_dst_rob_index = dst_q[i];
                bus.out_fu_set_nzcv      = set_nz_q[i];
                bus.out_fu_nzcv          = nz_val_q[i];
            end
        end
    end

    assign bus.out_fu_start = fu_start;
    assign bus.out_rs_ready = rs_ready;
    assign bus.out_rs_count = count_q;

    always_comb begin
        valid_d = valid_q & ~squash;
        if (issue_fire) valid_d = valid_d & ~grant;
        age_d = age_q;
        n_sq  = '0;
        for (int i = 0; i < DEPTH; i++) n_sq = n_sq + (IDX_W+1)'(squash[i]);
        if (disp_ok) begin
            valid_d[free_idx] = 1'b1;
            for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = 1'b0;
            age_d[free_idx] = valid_q;
        end
        count_d = count_q - n_sq + (IDX_W+1)'(disp_ok) - (IDX_W+1)'(issue_fire);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            age_q   <= age_d;
        end
    end

    // Entry payload: no reset, only meaningful while valid_q is set.
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_ok && free_idx == IDX_W'(i)) begin
                op_q[i]     <= bus.in_rob_fu_op;
                a_vld_q[i]  <= bus.in_rob_val_a_valid | a_hit;
                a_val_q[i]  <= a_hit ? bus.in_rob_broadcast_value : bus.in_rob_val_a_value;
                a_tag_q[i]  <= bus.in_rob_val_a_rob_index;
                b_vld_q[i]  <= bus.in_rob_val_b_valid | b_hit;
                b_val_q[i]  <= b_hit ? bus.in_rob_broadcast_value : bus.in_rob_val_b_value;
                b_tag_q[i]  <= bus.in_rob_val_b_rob_index;
                use_nz_q[i] <= bus.in_rob_instr_uses_nzcv;
                nz_vld_q[i] <= bus.in_rob_nzcv_valid | nz_hit;
                nz_val_q[i] <= nz_hit ? bus.in_rob_broadcast_nzcv : bus.in_rob_nzcv;
                nz_tag_q[i] <= bus.in_rob_nzcv_rob_index;
                set_nz_q[i] <= bus.in_rob_set_nzcv;
                dst_q[i]    <= bus.in_rob_dst_rob_index;
            end else begin
                if (wake_a[i]) begin
                    a_vld_q[i] <= 1'b1;
                    a_val_q[i] <= bus.in_rob_broadcast_value;
                end
                if (wake_b[i]) begin
                    b_vld_q[i] <= 1'b1;
                    b_val_q[i] <= bus.in_rob_broadcast_value;
                end
                if (wake_nz[i]) begin
                    nz_vld_q[i] <= 1'b1;
                    nz_val_q[i] <= bus.in_rob_broadcast_nzcv;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_age_station.sv
// Directed bench for rs_age_station: issue order, bypass, full, squash and NZCV wakeup.
module tb_rs_age_station;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rs_age_station_if #(.IDX_W(3), .VAL_W(64), .ROB_IDX_W(4), .OP_W(5)) bus ();

    rs_age_station #(.DEPTH(8), .IDX_W(3), .VAL_W(64), .ROB_IDX_W(4), .OP_W(5)) dut (
        .in_clk(clk),
        .in_rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.in_rob_done = 0;               bus.in_rob_fu_op = '0;
        bus.in_rob_val_a_valid = 0;        bus.in_rob_val_a_value = '0;  bus.in_rob_val_a_rob_index = '0;
        bus.in_rob_val_b_valid = 0;        bus.in_rob_val_b_value = '0;  bus.in_rob_val_b_rob_index = '0;
        bus.in_rob_instr_uses_nzcv = 0;    bus.in_rob_nzcv_valid = 0;    bus.in_rob_nzcv = '0;
        bus.in_rob_nzcv_rob_index = '0;    bus.in_rob_set_nzcv = 0;      bus.in_rob_dst_rob_index = '0;
        bus.in_rob_broadcast_done = 0;     bus.in_rob_broadcast_index = '0;
        bus.in_rob_broadcast_value = '0;   bus.in_rob_broadcast_set_nzcv = 0;
        bus.in_rob_broadcast_nzcv = '0;    bus.in_rob_is_mispred = 0;    bus.in_rob_mispred_index = '0;
    endtask

    task automatic disp(input logic [4:0] op, input logic av, input logic [63:0] aval,
                        input logic [3:0] atag, input logic [63:0] bval, input logic [3:0] dst);
        bus.in_rob_done = 1;
        bus.in_rob_fu_op = op;
        bus.in_rob_val_a_valid = av;
        bus.in_rob_val_a_value = aval;
        bus.in_rob_val_a_rob_index = atag;
        bus.in_rob_val_b_valid = 1;
        bus.in_rob_val_b_value = bval;
        bus.in_rob_dst_rob_index = dst;
    endtask

    task automatic bcast(input logic [3:0] idx, input logic [63:0] val, input logic setnz, input logic [3:0] nz);
        bus.in_rob_broadcast_done = 1;
        bus.in_rob_broadcast_index = idx;
        bus.in_rob_broadcast_value = val;
        bus.in_rob_broadcast_set_nzcv = setnz;
        bus.in_rob_broadcast_nzcv = nz;
    endtask

    task automatic do_reset;
        rst = 1;
        idle();
        bus.in_fu_ready = 0;
        bus.in_rob_head_index = '0;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (bus.out_rs_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.out_rs_count); end
        checks++; if (bus.out_rs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.out_rs_ready); end
        checks++; if (bus.out_fu_start !== 1'b0 || bus.out_fu_val_a !== 64'd0 || bus.out_fu_op !== 5'd0)
            begin errors++; $display("FAIL reset_issue got start=%0b a=%0h op=%0d want 0/0/0", bus.out_fu_start, bus.out_fu_val_a, bus.out_fu_op); end
    endtask

    task automatic test_basic;
        do_reset();
        bus.in_fu_ready = 1;
        disp(5'd3, 1, 64'd5, 4'd0, 64'd7, 4'd1);
        #1;
        checks++; if (bus.out_fu_start !== 1'b0) begin errors++; $display("FAIL basic_no_comb_issue got %0b want 0", bus.out_fu_start); end
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_start !== 1'b1 || bus.out_fu_op !== 5'd3 || bus.out_fu_dst_rob_index !== 4'd1)
            begin errors++; $display("FAIL basic_issue got start=%0b op=%0d dst=%0d want 1/3/1", bus.out_fu_start, bus.out_fu_op, bus.out_fu_dst_rob_index); end
        checks++; if (bus.out_fu_val_a !== 64'd5 || bus.out_fu_val_b !== 64'd7)
            begin errors++; $display("FAIL basic_vals got a=%0d b=%0d want 5/7", bus.out_fu_val_a, bus.out_fu_val_b); end
        checks++; if (bus.out_rs_count !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", bus.out_rs_count); end
        tick();
        checks++; if (bus.out_rs_count !== 4'd0 || bus.out_fu_start !== 1'b0 || bus.out_fu_val_a !== 64'd0)
            begin errors++; $display("FAIL basic_drain got cnt=%0d start=%0b a=%0h want 0/0/0", bus.out_rs_count, bus.out_fu_start, bus.out_fu_val_a); end
    endtask

    task automatic test_order;
        do_reset();
        disp(5'd1, 1, 64'd10, 4'd0, 64'd11, 4'd2);
        tick();
        disp(5'd2, 1, 64'd20, 4'd0, 64'd21, 4'd3);
        tick();
        idle();
        tick();
        tick();
        tick();
        checks++; if (bus.out_fu_dst_rob_index !== 4'd2 || bus.out_rs_count !== 4'd2)
            begin errors++; $display("FAIL order_hold got dst=%0d cnt=%0d want 2/2", bus.out_fu_dst_rob_index, bus.out_rs_count); end
        bus.in_fu_ready = 1;
        tick();
        checks++; if (bus.out_fu_dst_rob_index !== 4'd3 || bus.out_fu_val_a !== 64'd20)
            begin errors++; $display("FAIL order_second got dst=%0d a=%0d want 3/20", bus.out_fu_dst_rob_index, bus.out_fu_val_a); end
        tick();
        bus.in_fu_ready = 0;
        checks++; if (bus.out_rs_count !== 4'd0) begin errors++; $display("FAIL order_drain got %0d want 0", bus.out_rs_count); end
    endtask

    task automatic test_bypass;
        do_reset();
        disp(5'd4, 0, 64'd0, 4'd6, 64'd1, 4'd4);
        bcast(4'd6, 64'h2A, 0, 4'd0);
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_start !== 1'b1 || bus.out_fu_val_a !== 64'h2A)
            begin errors++; $display("FAIL bypass got start=%0b a=%0h want 1/2a", bus.out_fu_start, bus.out_fu_val_a); end
    endtask

    task automatic test_age;
        do_reset();
        disp(5'd1, 0, 64'd0, 4'd9, 64'h5B, 4'd5);
        tick();
        disp(5'd1, 1, 64'hA1, 4'd0, 64'd0, 4'd6);
        tick();
        disp(5'd1, 1, 64'hB1, 4'd0, 64'd0, 4'd7);
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_dst_rob_index !== 4'd6 || bus.out_rs_count !== 4'd3)
            begin errors++; $display("FAIL age_first got dst=%0d cnt=%0d want 6/3", bus.out_fu_dst_rob_index, bus.out_rs_count); end
        bus.in_fu_ready = 1;
        tick();
        bus.in_fu_ready = 0;
        disp(5'd1, 1, 64'hC1, 4'd0, 64'd0, 4'd8);
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_dst_rob_index !== 4'd7 || bus.out_rs_count !== 4'd3)
            begin errors++; $display("FAIL age_slot_reuse got dst=%0d cnt=%0d want 7/3", bus.out_fu_dst_rob_index, bus.out_rs_count); end
        bcast(4'd9, 64'h99, 0, 4'd0);
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_dst_rob_index !== 4'd5 || bus.out_fu_val_a !== 64'h99)
            begin errors++; $display("FAIL age_woken_oldest got dst=%0d a=%0h want 5/99", bus.out_fu_dst_rob_index, bus.out_fu_val_a); end
        bus.in_fu_ready = 1;
        tick();
        tick();
        checks++; if (bus.out_fu_dst_rob_index !== 4'd8 || bus.out_fu_val_a !== 64'hC1)
            begin errors++; $display("FAIL age_last got dst=%0d a=%0h want 8/c1", bus.out_fu_dst_rob_index, bus.out_fu_val_a); end
        tick();
        bus.in_fu_ready = 0;
        checks++; if (bus.out_rs_count !== 4'd0) begin errors++; $display("FAIL age_drain got %0d want 0", bus.out_rs_count); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            disp(5'd1, 0, 64'd0, 4'(i), 64'(i), 4'(i));
            tick();
        end
        idle();
        #1;
        checks++; if (bus.out_rs_count !== 4'd8 || bus.out_rs_ready !== 1'b0)
            begin errors++; $display("FAIL full_state got cnt=%0d rdy=%0b want 8/0", bus.out_rs_count, bus.out_rs_ready); end
        disp(5'd2, 1, 64'h77, 4'd0, 64'd0, 4'd12);
        tick();
        idle();
        #1;
        checks++; if (bus.out_rs_count !== 4'd8 || bus.out_fu_start !== 1'b0)
            begin errors++; $display("FAIL full_drop got cnt=%0d start=%0b want 8/0", bus.out_rs_count, bus.out_fu_start); end
        bcast(4'd3, 64'h33, 0, 4'd0);
        #1;
        checks++; if (bus.out_fu_start !== 1'b0) begin errors++; $display("FAIL full_no_comb_wake got %0b want 0", bus.out_fu_start); end
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_start !== 1'b1 || bus.out_fu_val_a !== 64'h33 || bus.out_fu_val_b !== 64'd3)
            begin errors++; $display("FAIL full_wake got start=%0b a=%0h b=%0d want 1/33/3", bus.out_fu_start, bus.out_fu_val_a, bus.out_fu_val_b); end
        bus.in_fu_ready = 1;
        disp(5'd2, 1, 64'h77, 4'd0, 64'd0, 4'd12);
        #1;
        checks++; if (bus.out_rs_ready !== 1'b0) begin errors++; $display("FAIL full_ready_during_issue got %0b want 0", bus.out_rs_ready); end
        tick();
        idle();
        bus.in_fu_ready = 0;
        #1;
        checks++; if (bus.out_rs_count !== 4'd7 || bus.out_rs_ready !== 1'b1 || bus.out_fu_start !== 1'b0)
            begin errors++; $display("FAIL full_after_issue got cnt=%0d rdy=%0b start=%0b want 7/1/0", bus.out_rs_count, bus.out_rs_ready, bus.out_fu_start); end
    endtask

    task automatic test_squash;
        do_reset();
        bus.in_rob_head_index = 4'd14;
        disp(5'd1, 1, 64'h15, 4'd0, 64'd0, 4'd15);
        tick();
        disp(5'd1, 1, 64'h10, 4'd0, 64'd0, 4'd0);
        tick();
        disp(5'd1, 1, 64'h11, 4'd0, 64'd0, 4'd1);
        tick();
        disp(5'd1, 1, 64'h12, 4'd0, 64'd0, 4'd2);
        bus.in_rob_is_mispred = 1;
        bus.in_rob_mispred_index = 4'd0;
        bus.in_fu_ready = 1;
        #1;
        checks++; if (bus.out_fu_start !== 1'b0 || bus.out_fu_dst_rob_index !== 4'd0 || bus.out_rs_count !== 4'd3)
            begin errors++; $display("FAIL squash_suppress got start=%0b dst=%0d cnt=%0d want 0/0/3", bus.out_fu_start, bus.out_fu_dst_rob_index, bus.out_rs_count); end
        tick();
        idle();
        #1;
        checks++; if (bus.out_rs_count !== 4'd2 || bus.out_fu_dst_rob_index !== 4'd15)
            begin errors++; $display("FAIL squash_count got cnt=%0d dst=%0d want 2/15", bus.out_rs_count, bus.out_fu_dst_rob_index); end
        tick();
        checks++; if (bus.out_fu_dst_rob_index !== 4'd0 || bus.out_fu_val_a !== 64'h10)
            begin errors++; $display("FAIL squash_survivor got dst=%0d a=%0h want 0/10", bus.out_fu_dst_rob_index, bus.out_fu_val_a); end
        tick();
        bus.in_fu_ready = 0;
        checks++; if (bus.out_rs_count !== 4'd0 || bus.out_fu_start !== 1'b0)
            begin errors++; $display("FAIL squash_drain got cnt=%0d start=%0b want 0/0", bus.out_rs_count, bus.out_fu_start); end
    endtask

    task automatic test_nzcv;
        do_reset();
        bus.in_fu_ready = 1;
        disp(5'd6, 1, 64'd1, 4'd0, 64'd2, 4'd9);
        bus.in_rob_instr_uses_nzcv = 1;
        bus.in_rob_nzcv_rob_index = 4'd4;
        bus.in_rob_set_nzcv = 1;
        tick();
        idle();
        bcast(4'd4, 64'h55, 0, 4'b1111);
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_start !== 1'b0 || bus.out_rs_count !== 4'd1)
            begin errors++; $display("FAIL nzcv_no_set got start=%0b cnt=%0d want 0/1", bus.out_fu_start, bus.out_rs_count); end
        bcast(4'd4, 64'h66, 1, 4'b0100);
        tick();
        idle();
        #1;
        checks++; if (bus.out_fu_start !== 1'b1 || bus.out_fu_nzcv !== 4'b0100 || bus.out_fu_set_nzcv !== 1'b1 || bus.out_fu_val_a !== 64'd1)
            begin errors++; $display("FAIL nzcv_wake got start=%0b nzcv=%b set=%0b a=%0h want 1/0100/1/1", bus.out_fu_start, bus.out_fu_nzcv, bus.out_fu_set_nzcv, bus.out_fu_val_a); end
        tick();
        bus.in_fu_ready = 0;
        checks++; if (bus.out_rs_count !== 4'd0) begin errors++; $display("FAIL nzcv_drain got %0d want 0", bus.out_rs_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        idle();
        bus.in_fu_ready = 0;
        bus.in_rob_head_index = '0;
        test_reset();
        test_basic();
        test_order();
        test_bypass();
        test_age();
        test_full();
        test_squash();
        test_nzcv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
